// File: rtl/cpu64_obi_pkg.sv
// cpu64_obi_pkg: shared OBI width constants and responder FSM state type
package cpu64_obi_pkg;

    localparam int OBI_DATA_W  = 64;
    localparam int OBI_ADDR_W  = 39;
    localparam int OBI_BE_BITS = OBI_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        RSP      = 2'd2
    } obi_state_e;

endpackage

// File: rtl/cpu64_obi_wait_cnt.sv
// cpu64_obi_wait_cnt: loadable down-counter with zero flag for grant/response wait-states
module cpu64_obi_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // load has priority; decrement saturates at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && !zero)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu64_obi_mem_responder.sv
// cpu64_obi_mem_responder: OBI slave with programmable grant/response wait-states in front of a 1-cycle SRAM
module cpu64_obi_mem_responder
    import cpu64_obi_pkg::*;
#(
    parameter int DATA_W  = OBI_DATA_W,
    parameter int ADDR_W  = OBI_ADDR_W,
    parameter int BE_BITS = DATA_W / 8,
    parameter int MEM_AW  = 12,
    parameter int CNT_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [BE_BITS-1:0] be_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [DATA_W-1:0]  rdata_o,
    input  logic [CNT_W-1:0]   gnt_wait_i,
    input  logic [CNT_W-1:0]   rsp_wait_i,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [BE_BITS-1:0] mem_be_o,
    output logic [MEM_AW-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    localparam int OFF = $clog2(BE_BITS);

    obi_state_e        state_q, state_d;
    logic              cnt_zero, cnt_load, accept, grant, rd_first_q;
    logic [CNT_W-1:0]  cnt_val;
    logic [DATA_W-1:0] rdata_q;
    logic              unused_addr;

    assign unused_addr = ^{addr_i[ADDR_W-1:OFF+MEM_AW], addr_i[OFF-1:0]};

    cpu64_obi_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state_q != IDLE),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next state: the rvalid cycle of RSP accepts a new request exactly like IDLE
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_GNT)
            state_d = !req_i ? IDLE : (!cnt_zero ? WAIT_GNT : (we_i ? IDLE : RSP));
        else if (state_q == RSP && !cnt_zero)
            state_d = RSP;
        else
            state_d = !accept ? IDLE : (!grant ? WAIT_GNT : (we_i ? IDLE : RSP));
    end

    // outputs: grant decode, counter control, SRAM strobes and read data mux
    always_comb begin
        accept      = rst_ni && req_i && (state_q == IDLE || (state_q == RSP && cnt_zero));
        grant       = (accept && gnt_wait_i == '0) || (rst_ni && state_q == WAIT_GNT && req_i && cnt_zero);
        cnt_load    = grant ? !we_i : accept;
        cnt_val     = grant ? rsp_wait_i : gnt_wait_i - 1'b1;
        gnt_o       = grant;
        rvalid_o    = (state_q == RSP) && cnt_zero;
        mem_en_o    = grant;
        mem_we_o    = grant && we_i;
        mem_be_o    = grant ? be_i : '0;
        mem_addr_o  = addr_i[OFF +: MEM_AW];
        mem_wdata_o = wdata_i;
        rdata_o     = !rvalid_o ? '0 : (rd_first_q ? mem_rdata_i : rdata_q);
    end

    // SRAM data is only valid the cycle after the read enable, so hold it for delayed responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_first_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_first_q <= grant && !we_i;
            if (rd_first_q)
                rdata_q <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_cpu64_obi_mem_responder.sv
// tb_cpu64_obi_mem_responder: directed scoreboard bench for the OBI memory responder
module tb_cpu64_obi_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [7:0]  be_i = '0;
    logic [38:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        gnt_o, rvalid_o;
    logic [63:0] rdata_o;
    logic [3:0]  gnt_wait_i = '0, rsp_wait_i = '0;
    logic        mem_en_o, mem_we_o;
    logic [7:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i = '0;

    typedef struct {
        longint      cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] mem [4096];
    longint      cyc = 0;
    int          n_cmp = 0, n_err = 0;

    cpu64_obi_mem_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .gnt_wait_i  (gnt_wait_i),
        .rsp_wait_i  (rsp_wait_i),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, poison data on cycles without a read
    always @(posedge clk_i) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 64'(i);
            mem[2] <= 64'hDEAD_BEEF_0000_0001;
            mem[3] <= 64'hAAAA_BBBB_CCCC_DDDD;
            mem[5] <= 64'h5555_0000_5555_0005;
            mem[6] <= 64'h6666_0000_6666_0006;
        end else begin
            mem_rdata_i <= 64'hBAD0_BAD0_BAD0_BAD0;
            if (mem_en_o) begin
                if (mem_we_o) begin
                    for (int b = 0; b < 8; b++)
                        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end else begin
                    mem_rdata_i <= mem[mem_addr_o];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // monitor: every rvalid pops one expected response; rdata must be zero otherwise
    always @(negedge clk_i) begin
        if (rvalid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rvalid_unexpected: got rvalid=1 at cycle %0d expected no response", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("rdata", rdata_o, mon_e.data);
            end
        end else begin
            chk("rdata_idle", rdata_o, 64'h0);
        end
    end

    // drive one request; attributes are garbage until the expected grant cycle `lat`
    task automatic do_txn(input string nm, input logic w, input logic [7:0] be, input logic [38:0] a,
                          input logic [63:0] wd, input logic [3:0] gw, input logic [3:0] rw,
                          input int lat, input logic [63:0] exp_rd);
        req_i      = 1'b1;
        we_i       = w;
        gnt_wait_i = gw;
        rsp_wait_i = rw;
        for (int k = 0; k <= lat; k++) begin
            addr_i  = (k == lat) ? a : 39'h7F_FFFF_FFF8;
            wdata_i = (k == lat) ? wd : 64'hFFFF_FFFF_FFFF_FFFF;
            be_i    = (k == lat) ? be : 8'hFF;
            @(negedge clk_i);
            chk({nm, "_gnt"}, 64'(gnt_o), 64'(k == lat));
            chk({nm, "_mem_en"}, 64'(mem_en_o), 64'(k == lat));
            if (k == lat) begin
                chk({nm, "_mem_addr"}, 64'(mem_addr_o), 64'(a[14:3]));
                chk({nm, "_mem_we"}, 64'(mem_we_o), 64'(w));
                if (!w) sb.push_back('{cyc + 1 + longint'(rw), exp_rd});
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        // reset: outputs stay low even with a grantable request present
        repeat (3) @(posedge clk_i);
        #1;
        req_i = 1'b1;
        we_i  = 1'b1;
        #2;
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_mem_en", 64'(mem_en_o), 64'h0);
        chk("rst_mem_we", 64'(mem_we_o), 64'h0);
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // zero-wait read right after reset release
        do_txn("rd0", 1'b0, 8'hFF, 39'h10, 64'h0, 4'd0, 4'd0, 0, 64'hDEAD_BEEF_0000_0001);
        idle(3);

        // 3 grant wait-states, partial write, then readback through the held data path
        do_txn("wr_gw3", 1'b1, 8'h0F, 39'h18, 64'h1122_3344_5566_7788, 4'd3, 4'd0, 3, 64'h0);
        idle(1);
        do_txn("rb3", 1'b0, 8'hFF, 39'h18, 64'h0, 4'd0, 4'd1, 0, 64'hAAAA_BBBB_5566_7788);
        idle(4);

        // two reads with rsp_wait=2; the second grant lands on the first rvalid
        do_txn("rdA", 1'b0, 8'hFF, 39'h28, 64'h0, 4'd0, 4'd2, 0, 64'h5555_0000_5555_0005);
        do_txn("rdB", 1'b0, 8'hFF, 39'h30, 64'h0, 4'd0, 4'd2, 2, 64'h6666_0000_6666_0006);
        idle(5);

        // request abandoned during grant wait-states
        req_i      = 1'b1;
        we_i       = 1'b0;
        gnt_wait_i = 4'd4;
        addr_i     = 39'h10;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                req_i      = 1'b0;
                gnt_wait_i = 4'd0;
            end
            @(negedge clk_i);
            chk("drop_gnt", 64'(gnt_o), 64'h0);
            chk("drop_mem_en", 64'(mem_en_o), 64'h0);
            @(posedge clk_i);
            #1;
        end
        do_txn("after_drop", 1'b0, 8'hFF, 39'h10, 64'h0, 4'd0, 4'd0, 0, 64'hDEAD_BEEF_0000_0001);
        idle(2);

        // four back-to-back writes, each granted in its own cycle
        do_txn("bb0", 1'b1, 8'hFF, 39'h40, 64'hA0A0_A0A0_0000_0008, 4'd0, 4'd0, 0, 64'h0);
        do_txn("bb1", 1'b1, 8'hFF, 39'h48, 64'hA0A0_A0A0_0000_0009, 4'd0, 4'd0, 0, 64'h0);
        do_txn("bb2", 1'b1, 8'hFF, 39'h50, 64'hA0A0_A0A0_0000_000A, 4'd0, 4'd0, 0, 64'h0);
        do_txn("bb3", 1'b1, 8'hFF, 39'h58, 64'hA0A0_A0A0_0000_000B, 4'd0, 4'd0, 0, 64'h0);
        do_txn("bb_rb", 1'b0, 8'hFF, 39'h50, 64'h0, 4'd0, 4'd0, 0, 64'hA0A0_A0A0_0000_000A);
        idle(3);

        // reset in the middle of a long response wait discards the response
        do_txn("rst_rd", 1'b0, 8'hFF, 39'h28, 64'h0, 4'd0, 4'd5, 0, 64'h5555_0000_5555_0005);
        idle(2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(gnt_o), 64'h0);
        chk("mid_rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("mid_rst_mem_en", 64'(mem_en_o), 64'h0);
        chk("mid_rst_mem_we", 64'(mem_we_o), 64'h0);
        chk("mid_rst_rdata", rdata_o, 64'h0);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(10);
        do_txn("post_rst", 1'b0, 8'hFF, 39'h18, 64'h0, 4'd0, 4'd0, 0, 64'hAAAA_BBBB_5566_7788);
        idle(3);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu64_obi_mem_responder.md
CPU64_OBI_MEM_RESPONDER -- requirements
Module: cpu64_obi_mem_responder

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 64, OBI data width; ADDR_W, 39, OBI byte-address width; BE_BITS, DATA_W/8, byte strobes; MEM_AW, 12, backing-SRAM word-address width; CNT_W, 4, wait-state counter width.
REQ-002 Ports (name, direction, width, meaning): clk_i in 1 system clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-003 req_i in 1 OBI request; we_i in 1 write enable; be_i in BE_BITS byte strobes; addr_i in ADDR_W byte address; wdata_i in DATA_W write data.
REQ-004 gnt_o out 1 grant; rvalid_o out 1 read response valid; rdata_o out DATA_W read data.
REQ-005 gnt_wait_i in CNT_W grant wait-states; rsp_wait_i in CNT_W response wait-states; both sampled only in the cycles defined below.
REQ-006 mem_en_o out 1 SRAM enable; mem_we_o out 1 SRAM write; mem_be_o out BE_BITS; mem_addr_o out MEM_AW; mem_wdata_o out DATA_W; mem_rdata_i in DATA_W, valid the cycle after a read enable.

Function
REQ-007 FSM states: IDLE, WAIT_GNT, RSP; encoding 2 bits.
REQ-008 IDLE, req_i=1, gnt_wait_i=0: gnt_o=1 combinationally that cycle (grant cycle G).
REQ-009 IDLE, req_i=1, gnt_wait_i=N>0: load counter N-1, go WAIT_GNT; gnt_o=0.
REQ-010 WAIT_GNT: counter decrements each cycle; gnt_o=req_i when counter=0; req_i=0 in any WAIT_GNT cycle: return IDLE, no SRAM access.
REQ-011 Grant cycle: mem_en_o=1, mem_we_o=we_i, mem_be_o=be_i, mem_wdata_o=wdata_i, mem_addr_o=addr_i[log2(BE_BITS)+MEM_AW-1:log2(BE_BITS)]; upper address bits ignored; mem_en_o=0 in all other cycles.
REQ-012 Granted write: no response; next state IDLE; back-to-back writes granted every cycle when gnt_wait_i=0.
REQ-013 Granted read: sample rsp_wait_i=M into counter, go RSP; G+1 captures mem_rdata_i into rdata_q.
REQ-014 RSP: rvalid_o=1 when counter=0; counter decrements otherwise; rvalid_o asserts exactly cycle G+1+M, for one cycle.
REQ-015 rdata_o = mem_rdata_i in cycle G+1, else rdata_q; rdata_o=0 when rvalid_o=0.
REQ-016 Single outstanding read: gnt_o=0 in RSP except the rvalid_o cycle, where a new request is processed per REQ-008/009 (pipelined grant with gnt_wait_i=0).
REQ-017 No response for writes; writes never reorder with reads (one transaction in flight).
REQ-018 Request attributes held only at the grant cycle; changes of addr_i/wdata_i before grant are ignored.

Reset
REQ-019 Asynchronous on rst_ni=0: state IDLE, counter 0, rdata_q 0; gnt_o, rvalid_o, mem_en_o, mem_we_o = 0; rdata_o 0.
REQ-020 Reset mid-read discards the pending response; no rvalid_o after release until a new read is granted.
REQ-021 First grant possible in the first clock edge-cycle after rst_ni deasserts.

Structure
REQ-022 Shared package cpu64_obi_pkg holds the FSM state typedef/localparams and the OBI width constants (DATA_W, ADDR_W, BE_BITS defaults).
REQ-023 One sub-module cpu64_obi_wait_cnt: loadable CNT_W down-counter with zero flag, used for both grant and response waits.

Verification
REQ-024 gnt_wait=0, rsp_wait=0, read addr 0x10 (word 2 holds 0xDEAD_BEEF_0000_0001) -> gnt_o same cycle, rvalid_o next cycle, rdata_o=0xDEADBEEF00000001.
REQ-025 gnt_wait=3, write addr 0x18 be=0x0F wdata=0x1122334455667788 -> gnt_o 3 cycles after req_i; readback of word 3 = low 4 bytes 0x55667788, upper bytes unchanged.
REQ-026 rsp_wait=2, read then immediate second read -> rvalid_o at G+3; second gnt_o coincides with first rvalid_o; second rvalid_o at G+6.
REQ-027 gnt_wait=4, req_i dropped after 2 cycles -> no gnt_o, mem_en_o never asserted, FSM IDLE.
REQ-028 rst_ni asserted in RSP with rsp_wait=5 -> all outputs 0 immediately, no rvalid_o after release.
REQ-029 Four back-to-back writes, gnt_wait=0 -> gnt_o and mem_en_o high 4 consecutive cycles, rvalid_o never asserted.
